// File: rtl/cskip_serial_add_ctrl.sv
// Nibble-serial WIDTH-bit add/subtract sequencer around one 4-bit carry-skip slice.
// Optional skip-statistics counter and port enabled by defining CSKIP_SKIP_STATS_EN.

module fourbit_carry_skip_block (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       ci_i,
  output logic [3:0] s_o,
  output logic       co_o
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  always_comb begin
    // NOTE: every variable gets a default at the top of an always_comb so no path can infer a latch.
    g    = a_i & b_i;
    p    = a_i ^ b_i;
    c    = '0;
    c[0] = ci_i;
    for (int i = 0; i < 4; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    s_o  = p ^ c[3:0];
    // When every bit propagates, the incoming carry bypasses the ripple chain.
    co_o = (&p) ? ci_i : c[4];
  end

endmodule

module cskip_serial_add_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
`ifdef CSKIP_SKIP_STATS_EN
  ,
  output logic [$clog2(WIDTH/4+1)-1:0] skip_cnt
`endif
);

  localparam int NSLICE = WIDTH / 4;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NSLICE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic [IDXW-1:0]  idx_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] s_q;
  logic             cout_q;
  logic             ovf_q;

  logic [WIDTH-1:0] b_d;
  logic             carry_d;
  logic [3:0]       a_nib;
  logic [3:0]       b_nib;
  logic [3:0]       sum_nib;
  logic             slice_co;
  logic             last_step;

  // b_q holds the already-inverted operand, so subtraction is a + ~b + 1.
  always_comb begin
    b_d       = sub ? ~b : b;
    carry_d   = sub ? 1'b1 : cin;
    a_nib     = a_q[4*idx_q +: 4];
    b_nib     = b_q[4*idx_q +: 4];
    last_step = (idx_q == IDX_LAST);
  end

  fourbit_carry_skip_block u_slice (
    .a_i  (a_nib),
    .b_i  (b_nib),
    .ci_i (carry_q),
    .s_o  (sum_nib),
    .co_o (slice_co)
  );

`ifdef CSKIP_SKIP_STATS_EN
  localparam int SKW = $clog2(NSLICE + 1);
  logic [SKW-1:0] skip_q;
  logic           skip_hit;

  always_comb begin
    skip_hit = &(a_nib ^ b_nib);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      skip_q <= '0;
    end else if ((state_q != RUN) && start) begin
      skip_q <= '0;
    end else if ((state_q == RUN) && skip_hit) begin
      skip_q <= skip_q + 1'b1;
    end
  end

  assign skip_cnt = skip_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b_d;
            carry_q <= carry_d;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          s_q[4*idx_q +: 4] <= sum_nib;
          carry_q           <= slice_co;
          idx_q             <= idx_q + 1'b1;
          if (last_step) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            cout_q  <= slice_co;
            // Carry into the MSB xor carry out of it.
            ovf_q   <= a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ sum_nib[3] ^ slice_co;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign s    = s_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_cskip_serial_add_ctrl.sv
// Self-checking bench for cskip_serial_add_ctrl against an arithmetic reference model.
// Define CSKIP_SKIP_STATS_EN to also exercise the skip counter.

module tb_cskip_serial_add_ctrl;

  localparam int W  = 32;
  localparam int NS = W / 4;

  typedef struct packed {
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;
  } res_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         sub;
  logic         cin;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] s;
  logic         cout;
  logic         ovf;
`ifdef CSKIP_SKIP_STATS_EN
  logic [$clog2(NS+1)-1:0] skip_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cskip_serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .sub   (sub),
    .cin   (cin),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .s     (s),
    .cout  (cout),
    .ovf   (ovf)
`ifdef CSKIP_SKIP_STATS_EN
    ,
    .skip_cnt (skip_cnt)
`endif
  );

  // Reference: plain modular arithmetic and sign-based overflow.
  function automatic res_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic msub, input logic mcin);
    logic [W-1:0] bp;
    logic [W:0]   full;
    res_t         r;
    bp     = msub ? ~mb : mb;
    full   = {1'b0, ma} + {1'b0, bp} + {{W{1'b0}}, (msub ? 1'b1 : mcin)};
    r.s    = full[W-1:0];
    r.cout = full[W];
    r.ovf  = (ma[W-1] == bp[W-1]) && (full[W-1] != ma[W-1]);
    return r;
  endfunction

  function automatic int model_skips(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                     input logic msub);
    logic [W-1:0] x;
    int n;
    x = ma ^ (msub ? ~mb : mb);
    n = 0;
    for (int i = 0; i < NS; i++) begin
      if (x[4*i +: 4] == 4'hF) n++;
    end
    return n;
  endfunction

  // Launches one op, scrambles inputs while busy, returns at the negedge where done is seen.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tsub,
                        input logic tcin, input bit hold, output res_t r, output int lat,
                        output int bc);
    @(negedge clk);
    a = ta; b = tb; sub = tsub; cin = tcin; start = 1'b1;
    @(negedge clk);
    start = hold;
    lat = 0;
    bc  = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) bc++;
      a = $urandom; b = $urandom; sub = 1'($urandom); cin = 1'($urandom);
      @(negedge clk);
      lat++;
    end
    r = {s, cout, ovf};
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
    #1;
    total++;
    if ({busy, done, s, cout, ovf} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got busy=%b done=%b s=%h cout=%b ovf=%b exp all zero",
               busy, done, s, cout, ovf);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, done} !== 2'b00) begin
      bad++;
      $display("FAIL idle_after_reset got busy=%b done=%b exp 0 0", busy, done);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] va [3] = '{32'h0000_0001, 32'h7FFF_FFFF, 32'h0000_0005};
    logic [W-1:0] vb [3] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0007};
    logic         vs [3] = '{1'b0, 1'b0, 1'b1};
    logic         vc [3] = '{1'b0, 1'b0, 1'b1};
    res_t         ve [3] = '{{32'h0000_0000, 1'b1, 1'b0},
                             {32'h8000_0000, 1'b0, 1'b1},
                             {32'hFFFF_FFFE, 1'b0, 1'b0}};
    res_t r;
    int lat, bc;
    for (int i = 0; i < 3; i++) begin
      run_op(va[i], vb[i], vs[i], vc[i], 1'b0, r, lat, bc);
      total++;
      if (r !== ve[i]) begin
        bad++;
        $display("FAIL directed%0d_result got s=%h cout=%b ovf=%b exp s=%h cout=%b ovf=%b",
                 i, r.s, r.cout, r.ovf, ve[i].s, ve[i].cout, ve[i].ovf);
      end
      total++;
      if (lat !== NS || bc !== NS) begin
        bad++;
        $display("FAIL directed%0d_latency got done_after=%0d busy_cycles=%0d exp %0d %0d",
                 i, lat, bc, NS, NS);
      end
      @(negedge clk);
      total++;
      if (done !== 1'b0 || s !== ve[i].s) begin
        bad++;
        $display("FAIL directed%0d_pulse_hold got done=%b s=%h exp done=0 s=%h",
                 i, done, s, ve[i].s);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] corner [4] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};
    logic [W-1:0] ra, rb;
    logic rs, rc;
    res_t r, e;
    int lat, bc;
    for (int n = 0; n < 30; n++) begin
      ra = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
      rb = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
      rs = 1'($urandom);
      rc = 1'($urandom);
      e  = model(ra, rb, rs, rc);
      run_op(ra, rb, rs, rc, 1'b0, r, lat, bc);
      total++;
      if (r !== e || lat !== NS) begin
        bad++;
        $display("FAIL random%0d a=%h b=%h sub=%b cin=%b got s=%h cout=%b ovf=%b lat=%0d exp s=%h cout=%b ovf=%b lat=%0d",
                 n, ra, rb, rs, rc, r.s, r.cout, r.ovf, lat, e.s, e.cout, e.ovf, NS);
      end
`ifdef CSKIP_SKIP_STATS_EN
      total++;
      if (int'(skip_cnt) !== model_skips(ra, rb, rs)) begin
        bad++;
        $display("FAIL random%0d_skip got %0d exp %0d", n, skip_cnt, model_skips(ra, rb, rs));
      end
`endif
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] ta;
    res_t r, e;
    int lat, bc, k;
    ta = W'($urandom);
    e  = model(ta, 32'h1234_5678, 1'b0, 1'b1);
    run_op(ta, 32'h1234_5678, 1'b0, 1'b1, 1'b1, r, lat, bc);
    total++;
    if (r !== e || lat !== NS) begin
      bad++;
      $display("FAIL b2b_first got s=%h cout=%b ovf=%b lat=%0d exp s=%h cout=%b ovf=%b lat=%0d",
               r.s, r.cout, r.ovf, lat, e.s, e.cout, e.ovf, NS);
    end
    a = 32'h2; b = 32'h3; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if ({busy, done} !== 2'b10) begin
      bad++;
      $display("FAIL b2b_accept_in_done got busy=%b done=%b exp 1 0", busy, done);
    end
    k = 0;
    while (done !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (s !== 32'h5 || k !== NS) begin
      bad++;
      $display("FAIL b2b_second got s=%h lat=%0d exp s=00000005 lat=%0d", s, k, NS);
    end
  endtask

  task automatic test_reset_abort();
    res_t r;
    int lat, bc, seen;
    @(negedge clk);
    a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; sub = 1'b0; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    total++;
    if ({busy, done, s, cout} !== '0) begin
      bad++;
      $display("FAIL abort_reset_outputs got busy=%b done=%b s=%h cout=%b exp all zero",
               busy, done, s, cout);
    end
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL abort_no_done got %0d done pulses exp 0", seen);
    end
    run_op(32'h10, 32'h20, 1'b0, 1'b0, 1'b0, r, lat, bc);
    total++;
    if (r.s !== 32'h30 || lat !== NS) begin
      bad++;
      $display("FAIL abort_followup got s=%h lat=%0d exp s=00000030 lat=%0d", r.s, lat, NS);
    end
  endtask

`ifdef CSKIP_SKIP_STATS_EN
  task automatic test_skip_stats();
    res_t r;
    int lat, bc;
    run_op(32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1, 1'b0, r, lat, bc);
    total++;
    if (r.s !== 32'h0 || r.cout !== 1'b1 || int'(skip_cnt) !== NS) begin
      bad++;
      $display("FAIL skip_all got s=%h cout=%b skip=%0d exp s=00000000 cout=1 skip=%0d",
               r.s, r.cout, skip_cnt, NS);
    end
    run_op(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, r, lat, bc);
    total++;
    if (int'(skip_cnt) !== 0) begin
      bad++;
      $display("FAIL skip_none got skip=%0d exp 0", skip_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_abort();
`ifdef CSKIP_SKIP_STATS_EN
    test_skip_stats();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cskip_serial_add_ctrl.md
Name: cskip_serial_add_ctrl

Overview:
- Multi-cycle WIDTH-bit add/subtract sequencer built around one internal 4-bit carry-skip slice (fourbit_carry_skip_block).
- Feeds one nibble per cycle, least significant nibble first, and registers the slice carry between steps.
- Trades latency for area in the ARITH unit.
- Provides a start/busy/done handshake to the ALU control.

Parameters:
- WIDTH, 32, operand width; must be a multiple of 4 and at least 8.
- NSLICE, WIDTH/4, number of slice steps; derived, not overridden.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only when not busy.
- sub  input  1  1 computes a-b; 0 computes a+b+cin.
- cin  input  1  carry in; ignored when sub=1.
- a  input  WIDTH  operand A; latched on start acceptance.
- b  input  WIDTH  operand B; latched on start acceptance.
- busy  output  1  high while stepping.
- done  output  1  one-cycle pulse when the result is valid.
- s  output  WIDTH  result; held until the next accepted start.
- cout  output  1  carry out of the MSB (0 means borrow when sub=1).
- ovf  output  1  signed overflow.

Behaviour:
- Reset: asynchronous, active-high. Drives state=IDLE, busy=0, done=0, s=0, cout=0, ovf=0, step index=0, carry register=0. Aborts any operation in flight, and the aborted result is never reported.
- States: IDLE, RUN, DONE.
- IDLE: start=1 at an edge latches a, b' (b' = ~b if sub, else b), and carry register = (sub ? 1 : cin). Sets idx=0, goes to RUN, busy=1.
- RUN: each cycle the slice sees a_l[4*idx+:4], b'[4*idx+:4], carry register.
  - At the edge: s[4*idx+:4] is loaded, carry register <= slice cp, idx increments.
  - When idx=NSLICE-1 at the edge: go to DONE, busy=0, done=1, cout <= slice cp.
  - ovf <= a_l[MSB] ^ b'[MSB] ^ sum[MSB] ^ cp, i.e. carry into MSB xor carry out.
- DONE: lasts one cycle (done=1), then IDLE. start=1 in DONE is accepted exactly as in IDLE, which gives back-to-back operation.
- Latency: start accepted at edge E0, done high in the cycle after edge E0+NSLICE (8 cycles for WIDTH=32). Throughput is one operation per NSLICE+1 cycles.
- Writes to s: s nibbles are written progressively during RUN. s is defined valid only when done=1 or after it, until the next acceptance.
- start while busy: ignored, with no queueing. Operand changes during RUN have no effect.
- Arithmetic is modulo 2^WIDTH. The slice carry path (skip or ripple) is internal; results are identical either way.

Optional Feature:
- Macro: CSKIP_SKIP_STATS_EN.
- With it defined:
  - Extra output port skip_cnt, width $clog2(NSLICE+1).
  - Counts RUN steps whose nibble propagate term (&(a_l^b') for that nibble) was 1, i.e. steps where the slice bypassed its carry.
  - Cleared on reset and on start acceptance; final value is valid with done and held like s.
- Without it: the port and counter are absent, and all other behaviour is identical.

Test Plan:
- a=0x00000001, b=0xFFFFFFFF, sub=0, cin=0, start pulse -> busy for 8 cycles, done pulse 8 cycles after acceptance, s=0x00000000, cout=1, ovf=0.
- a=0x7FFFFFFF, b=0x00000001, sub=0, cin=0 -> s=0x80000000, cout=0, ovf=1.
- a=0x00000005, b=0x00000007, sub=1, cin=1 (ignored) -> s=0xFFFFFFFE, cout=0, ovf=0.
- Second start held high during RUN -> ignored; start asserted in the DONE cycle with a=2, b=3 -> accepted, next done gives s=0x00000005.
- reset pulsed 3 cycles into RUN -> busy=0, done=0, s=0, cout=0 immediately; no done for the aborted operation; following op a=0x10, b=0x20 -> s=0x30.
- With CSKIP_SKIP_STATS_EN: a=0xFFFFFFFF, b=0, cin=1 -> s=0, cout=1, skip_cnt=8. Then a=0, b=0 -> skip_cnt=0.
